// File: rtl/mlp_host_sequencer.sv
// mlp_host_sequencer
// Host-side job sequencer for the MLP datapath. A job arrives as a beat
// stream (four weight bytes, then NUM_ACT activation words). The sequencer
// replays it onto the weight-FIFO push and activation-write ports, then
// pulses start. It waits for layer completion, or aborts on a cycle budget,
// and returns the captured accumulator pair on a valid/ready response port.
// Every MLP-side and response output is driven from a flop.
module mlp_host_sequencer #(
  parameter int NUM_ACT = 2,
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [15:0] s_data,
  output logic        wf_reset,
  output logic        wf_push_col0,
  output logic        wf_push_col1,
  output logic [7:0]  wf_data_out,
  output logic        init_act_valid,
  output logic [15:0] init_act_data,
  output logic        start_mlp,
  output logic        weights_ready,
  input  logic        layer_complete,
  input  logic        acc_valid,
  input  logic [31:0] acc0,
  input  logic [31:0] acc1,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] res_acc0,
  output logic [31:0] res_acc1,
  output logic        res_timeout,
  output logic        busy,
  output logic [2:0]  state
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FLUSH = 3'd1,
    ST_WLOAD = 3'd2,
    ST_ALOAD = 3'd3,
    ST_START = 3'd4,
    ST_WAIT  = 3'd5,
    ST_RESP  = 3'd6
  } state_t;

  localparam logic [4:0]  LAST_ACT  = 5'(NUM_ACT - 1);
  localparam logic [15:0] TMO_LIMIT = 16'(TIMEOUT);

  state_t      state_q, state_d;
  logic [4:0]  beat_q, beat_d;
  logic [15:0] tmo_q, tmo_d;

  logic        wf_reset_q, wf_reset_d;
  logic        push0_q, push0_d;
  logic        push1_q, push1_d;
  logic [7:0]  wf_data_q, wf_data_d;
  logic        act_valid_q, act_valid_d;
  logic [15:0] act_data_q, act_data_d;
  logic        start_q, start_d;
  logic        wready_q, wready_d;
  logic        res_valid_q, res_valid_d;
  logic [31:0] res_acc0_q, res_acc0_d;
  logic [31:0] res_acc1_q, res_acc1_d;
  logic        res_timeout_q, res_timeout_d;

  logic        load_phase_s;
  logic        accept_s;

  assign load_phase_s = (state_q == ST_WLOAD) || (state_q == ST_ALOAD);
  assign accept_s     = load_phase_s && s_valid;

  // Next-state, counter, capture and pulse-output logic.
  always_comb begin
    state_d       = state_q;
    beat_d        = beat_q;
    tmo_d         = tmo_q;
    wf_reset_d    = 1'b0;
    push0_d       = 1'b0;
    push1_d       = 1'b0;
    wf_data_d     = wf_data_q;
    act_valid_d   = 1'b0;
    act_data_d    = act_data_q;
    res_acc0_d    = res_acc0_q;
    res_acc1_d    = res_acc1_q;
    res_timeout_d = res_timeout_q;

    case (state_q)
      ST_IDLE: begin
        // The waking beat is left on the bus; WLOAD consumes it.
        if (s_valid) begin
          state_d    = ST_FLUSH;
          wf_reset_d = 1'b1;
        end else begin
          state_d    = ST_IDLE;
        end
      end

      ST_FLUSH: begin
        beat_d  = 5'd0;
        state_d = ST_WLOAD;
      end

      ST_WLOAD: begin
        if (accept_s) begin
          wf_data_d = s_data[7:0];
          if (beat_q < 5'd2) begin
            push0_d = 1'b1;
          end else begin
            push1_d = 1'b1;
          end
          if (beat_q == 5'd3) begin
            beat_d  = 5'd0;
            state_d = ST_ALOAD;
          end else begin
            beat_d  = beat_q + 5'd1;
          end
        end else begin
          beat_d = beat_q;
        end
      end

      ST_ALOAD: begin
        if (accept_s) begin
          act_valid_d = 1'b1;
          act_data_d  = s_data;
          if (beat_q == LAST_ACT) begin
            beat_d  = 5'd0;
            state_d = ST_START;
          end else begin
            beat_d  = beat_q + 5'd1;
          end
        end else begin
          beat_d = beat_q;
        end
      end

      ST_START: begin
        tmo_d         = 16'd0;
        res_acc0_d    = 32'd0;
        res_acc1_d    = 32'd0;
        res_timeout_d = 1'b0;
        state_d       = ST_WAIT;
      end

      ST_WAIT: begin
        // Last acc_valid wins, including one coincident with completion.
        if (acc_valid) begin
          res_acc0_d = acc0;
          res_acc1_d = acc1;
        end else begin
          res_acc0_d = res_acc0_q;
          res_acc1_d = res_acc1_q;
        end
        // Completion is checked before the budget so it wins a tie.
        if (layer_complete) begin
          res_timeout_d = 1'b0;
          state_d       = ST_RESP;
        end else if (tmo_q == TMO_LIMIT) begin
          res_timeout_d = 1'b1;
          state_d       = ST_RESP;
        end else begin
          tmo_d = tmo_q + 16'd1;
        end
      end

      ST_RESP: begin
        if (res_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RESP;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    start_d     = (state_q == ST_START);
    wready_d    = (state_d == ST_WAIT);
    res_valid_d = (state_d == ST_RESP);
  end

  // State, counters and registered outputs; synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      beat_q        <= 5'd0;
      tmo_q         <= 16'd0;
      wf_reset_q    <= 1'b0;
      push0_q       <= 1'b0;
      push1_q       <= 1'b0;
      wf_data_q     <= 8'd0;
      act_valid_q   <= 1'b0;
      act_data_q    <= 16'd0;
      start_q       <= 1'b0;
      wready_q      <= 1'b0;
      res_valid_q   <= 1'b0;
      res_acc0_q    <= 32'd0;
      res_acc1_q    <= 32'd0;
      res_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      beat_q        <= beat_d;
      tmo_q         <= tmo_d;
      wf_reset_q    <= wf_reset_d;
      push0_q       <= push0_d;
      push1_q       <= push1_d;
      wf_data_q     <= wf_data_d;
      act_valid_q   <= act_valid_d;
      act_data_q    <= act_data_d;
      start_q       <= start_d;
      wready_q      <= wready_d;
      res_valid_q   <= res_valid_d;
      res_acc0_q    <= res_acc0_d;
      res_acc1_q    <= res_acc1_d;
      res_timeout_q <= res_timeout_d;
    end
  end

  assign s_ready        = load_phase_s;
  assign wf_reset       = wf_reset_q;
  assign wf_push_col0   = push0_q;
  assign wf_push_col1   = push1_q;
  assign wf_data_out    = wf_data_q;
  assign init_act_valid = act_valid_q;
  assign init_act_data  = act_data_q;
  assign start_mlp      = start_q;
  assign weights_ready  = wready_q;
  assign res_valid      = res_valid_q;
  assign res_acc0       = res_acc0_q;
  assign res_acc1       = res_acc1_q;
  assign res_timeout    = res_timeout_q;
  assign busy           = (state_q != ST_IDLE);
  assign state          = state_q;

endmodule
